// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: runs sequential ROM reads ahead of decode and handles MIPS delay-slot redirects.
// Optional build macro PFQ_PERF_CNT_EN adds saturating empty-cycle and flush counters.
module if_prefetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o
`ifdef PFQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_empty_o,
  output logic [31:0]       perf_flush_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [PW-1:0]     count, keep_n;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic              redir_pend, redir_pend_nxt;
  logic [ADDR_W-1:0] pend_target;

  logic empty, full, issue_ok, issue, pop, push;
  logic retain_q, set_pend;

  // ID handshake: id_valid_o is the valid, !stall_i is the ready; an entry
  // is consumed exactly on a cycle where both are high.
  always_comb begin
    count    = wr_ptr - rd_ptr;
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    issue_ok = !full && ((int'(count) + int'(inflight)) < DEPTH);
    pop      = !empty && !stall_i;
    // Entries left behind the (possibly departing) head decide delay-slot retention.
    keep_n   = count - {{AW{1'b0}}, pop};
    retain_q = branch_flag_i && (keep_n != '0);
    set_pend = branch_flag_i && (keep_n == '0) && !inflight;
    push     = inflight && !retain_q;
    issue    = rst && issue_ok && !branch_flag_i;

    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    if (retain_q) wr_ptr_nxt = rd_ptr_nxt + {{AW{1'b0}}, 1'b1};
    else          wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};

    fetch_pc_nxt   = fetch_pc;
    redir_pend_nxt = redir_pend;
    if (branch_flag_i) begin
      if (set_pend) redir_pend_nxt = 1'b1;
      else          fetch_pc_nxt   = branch_target_i;
    end else if (issue) begin
      // A pending redirect jumps to its target right after the delay-slot fetch.
      if (redir_pend) begin
        fetch_pc_nxt   = pend_target;
        redir_pend_nxt = 1'b0;
      end else begin
        fetch_pc_nxt = fetch_pc + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fetch_pc    <= RESET_PC;
      redir_pend  <= 1'b0;
      pend_target <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      inflight   <= issue;
      fetch_pc   <= fetch_pc_nxt;
      redir_pend <= redir_pend_nxt;
      if (issue)    inflight_pc <= fetch_pc;
      if (set_pend) pend_target <= branch_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem[wr_ptr[AW-1:0]]   <= inflight_pc;
      inst_mem[wr_ptr[AW-1:0]] <= rom_data_i;
    end
  end

  // Outputs are gated by rst so they read zero while reset is held.
  always_comb begin
    rom_ce_o   = issue;
    rom_addr_o = rst ? fetch_pc : '0;
    id_valid_o = rst && !empty;
    id_pc_o    = id_valid_o ? pc_mem[rd_ptr[AW-1:0]]   : '0;
    id_inst_o  = id_valid_o ? inst_mem[rd_ptr[AW-1:0]] : '0;
  end

`ifdef PFQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_empty_o <= '0;
      perf_flush_o <= '0;
    end else begin
      if (!id_valid_o && !stall_i && (perf_empty_o != 32'hFFFF_FFFF))
        perf_empty_o <= perf_empty_o + 32'd1;
      if (branch_flag_i && (perf_flush_o != 32'hFFFF_FFFF))
        perf_flush_o <= perf_flush_o + 32'd1;
    end
  end
`endif

  // Only one delay slot can be pending; a second redirect before it issues is illegal.
  redir_pend_single: assert property (@(posedge clk) disable iff (!rst)
    !(branch_flag_i && redir_pend));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench for if_prefetch_queue against a queue-based reference model,
// plus directed reset, stall, redirect and mid-operation reset scenarios.
module tb_if_prefetch_queue;
  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i = '0;
  logic              stall_i = 1'b0;
  logic              branch_flag_i = 1'b0;
  logic [ADDR_W-1:0] branch_target_i = '0;
  logic              id_valid_o;
  logic [ADDR_W-1:0] id_pc_o;
  logic [DATA_W-1:0] id_inst_o;
`ifdef PFQ_PERF_CNT_EN
  logic [31:0]       perf_empty_o, perf_flush_o;
`endif

  if_prefetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .stall_i(stall_i), .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o)
`ifdef PFQ_PERF_CNT_EN
    , .perf_empty_o(perf_empty_o), .perf_flush_o(perf_flush_o)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
  endfunction

  // Synchronous ROM: data one cycle after the request, junk otherwise.
  always @(posedge clk) rom_data_i <= rom_ce_o ? rom_fn(rom_addr_o) : $urandom();

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];          // {pc, inst} entries visible to ID, oldest first
  bit          m_infl;
  logic [31:0] m_infl_pc, m_fetch, m_pend_tgt;
  bit          m_pend;
  int          m_perf_empty, m_perf_flush;
  logic [31:0] seen_pc[$];        // PCs actually consumed by ID
  logic [31:0] iss_q[$];          // addresses actually requested from ROM

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_infl = 0; m_infl_pc = '0; m_fetch = RESET_PC;
    m_pend = 0; m_pend_tgt = '0;
    m_perf_empty = 0; m_perf_flush = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Hold reset low for n rising edges, checking outputs drop immediately.
  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    check("rst_ce",    rom_ce_o,   0);
    check("rst_addr",  rom_addr_o, 0);
    check("rst_valid", id_valid_o, 0);
    check("rst_pc",    id_pc_o,    0);
    check("rst_inst",  id_inst_o,  0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    stall_i = 1'b0; branch_flag_i = 1'b0;
    rst = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs at the negedge, compare, advance the model.
  task automatic cycle(input bit st, input bit br, input logic [31:0] tgt);
    bit          exp_ce, exp_v, set_pend;
    logic [63:0] resp;
    stall_i = st; branch_flag_i = br; branch_target_i = tgt;
    #1;
    exp_v  = (exp_q.size() != 0);
    exp_ce = ((exp_q.size() + int'(m_infl)) < DEPTH) && !br;
    check("rom_ce", rom_ce_o, exp_ce);
    if (exp_ce) check("rom_addr", rom_addr_o, m_fetch);
    check("id_valid", id_valid_o, exp_v);
    check("id_pc",   id_pc_o,   exp_v ? {32'h0, exp_q[0][63:32]} : 64'h0);
    check("id_inst", id_inst_o, exp_v ? {32'h0, exp_q[0][31:0]}  : 64'h0);
`ifdef PFQ_PERF_CNT_EN
    check("perf_empty", perf_empty_o, m_perf_empty);
    check("perf_flush", perf_flush_o, m_perf_flush);
    if (!exp_v && !st) m_perf_empty++;
    if (br) m_perf_flush++;
`endif
    if (rom_ce_o) iss_q.push_back(rom_addr_o);
    if (id_valid_o && !st) seen_pc.push_back(id_pc_o);

    // The entry leaving ID goes first; retention then applies to what remains.
    resp = {m_infl_pc, rom_fn(m_infl_pc)};
    if (exp_v && !st) void'(exp_q.pop_front());
    set_pend = 0;
    if (br && exp_q.size() != 0) begin
      while (exp_q.size() > 1) void'(exp_q.pop_back());
    end else if (m_infl) begin
      exp_q.push_back(resp);
    end else if (br) begin
      set_pend = 1;
    end
    if (exp_ce) begin
      m_infl_pc = m_fetch;
      if (m_pend) begin m_fetch = m_pend_tgt; m_pend = 0; end
      else m_fetch = m_fetch + 32'd4;
    end
    m_infl = exp_ce;
    if (set_pend) begin m_pend = 1; m_pend_tgt = tgt; end
    else if (br) m_fetch = tgt;

    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_v;
    int guard;
    int n_issue;
    bit br;
    logic [31:0] tgt;

    model_reset();
    @(negedge clk);

    // Reset release, sequential fetch, 2-cycle first-valid latency.
    do_reset(3);
    first_v = -1;
    for (int i = 0; i < 8; i++) begin
      if (id_valid_o && first_v < 0) first_v = i;
      cycle(0, 0, '0);
    end
    check("first_valid_latency", first_v, 2);

    // Stall held: exactly DEPTH issues, then drain without loss.
    do_reset(2);
    iss_q.delete(); seen_pc.delete();
    for (int i = 0; i < 10; i++) cycle(1, 0, '0);
    n_issue = iss_q.size();
    check("stall_issues", n_issue, DEPTH);
    for (int i = 0; i < 8; i++) cycle(0, 0, '0);
    check("stall_drain_0", seen_pc.size() > 3 ? seen_pc[0] : 32'hdead, 32'h0);
    check("stall_drain_3", seen_pc.size() > 3 ? seen_pc[3] : 32'hdead, 32'hc);

    // Redirect with a full queue 0x10..0x1C: only the delay slot survives.
    do_reset(2);
    guard = 0;
    while (!(exp_q.size() != 0 && exp_q[0][63:32] == 32'h10) && guard < 50) begin
      cycle(0, 0, '0); guard++;
    end
    check("t3_reach_head", guard < 50, 1);
    guard = 0;
    while (exp_q.size() != DEPTH && guard < 20) begin
      cycle(1, 0, '0); guard++;
    end
    check("t3_full", exp_q.size(), DEPTH);
    seen_pc.delete();
    cycle(1, 1, 32'h100);
    for (int i = 0; i < 8; i++) cycle(0, 0, '0);
    check("t3_order_len", seen_pc.size() >= 3, 1);
    if (seen_pc.size() >= 3) begin
      check("t3_delay_slot", seen_pc[0], 32'h10);
      check("t3_target",     seen_pc[1], 32'h100);
      check("t3_target_p4",  seen_pc[2], 32'h104);
    end

    // Redirect on empty queue with nothing in flight: delay slot fetched first.
    do_reset(2);
    iss_q.delete(); seen_pc.delete();
    cycle(0, 1, 32'h200);
    for (int i = 0; i < 6; i++) cycle(0, 0, '0);
    check("t4_iss_len", iss_q.size() >= 2, 1);
    if (iss_q.size() >= 2) begin
      check("t4_iss0", iss_q[0], RESET_PC);
      check("t4_iss1", iss_q[1], 32'h200);
    end
    check("t4_id_len", seen_pc.size() >= 2, 1);
    if (seen_pc.size() >= 2) begin
      check("t4_id0", seen_pc[0], RESET_PC);
      check("t4_id1", seen_pc[1], 32'h200);
    end

    // Reset while a fetch is in flight: stale response must not appear.
    do_reset(2);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0);
    check("t5_inflight", m_infl, 1);
    do_reset(2);
    iss_q.delete();
    for (int i = 0; i < 5; i++) cycle(0, 0, '0);
    check("t5_first_fetch", iss_q.size() != 0 ? iss_q[0] : 32'hdead, RESET_PC);

    // Randomized traffic with stalls, redirects and address wrap.
    do_reset(2);
    for (int i = 0; i < 1500; i++) begin
      br  = !m_pend && ($urandom_range(0, 99) < 10);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)))
                                        : ($urandom() & 32'hFFFF_FFFC);
      cycle($urandom_range(0, 99) < 30, br, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
